// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter: default widths,
// controller states and memory mode encodings.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin winner select: on a tie the requester that was not
// granted last wins; a lone requester always wins.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  // pick the winning index from the current request pair
  always_comb begin
    grant = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto a single-port memory with combinational
// read data; one access every three cycles (IDLE -> ACCESS -> RESP).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_mode,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_dataIn,
  input  logic [DATA_W-1:0] mem_dataOut
);

  state_t              state_r, state_s;
  logic                idx_r, idx_s;
  logic                we_r, we_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [DATA_W-1:0]   wdata_r, wdata_s;
  logic                last_r, last_s;
  logic                win_s;
  logic [1:0]          gnt_r, gnt_s;
  logic [1:0]          rvalid_r, rvalid_s;
  logic [1:0]          cap_s;
  logic                mode_r, mode_s;
  logic [ADDR_W-1:0]   maddr_r, maddr_s;
  logic [DATA_W-1:0]   mdin_r, mdin_s;
  logic [DATA_W-1:0]   rdata0_r, rdata1_r;

  rr_arbiter2 u_rr (
    .req   ({r1_req, r0_req}),
    .last  (last_r),
    .grant (win_s)
  );

  // next state, command latch and next values of the registered outputs
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    we_s     = we_r;
    addr_s   = addr_r;
    wdata_s  = wdata_r;
    last_s   = last_r;
    gnt_s    = 2'b00;
    rvalid_s = 2'b00;
    cap_s    = 2'b00;
    mode_s   = MODE_READ;
    maddr_s  = {ADDR_W{1'b0}};
    mdin_s   = {DATA_W{1'b0}};
    case (state_r)
      IDLE: begin
        if (r0_req || r1_req) begin
          state_s = ACCESS;
          idx_s   = win_s;
          last_s  = win_s;
          if (win_s) begin
            we_s    = r1_we;
            addr_s  = r1_addr;
            wdata_s = r1_wdata;
          end else begin
            we_s    = r0_we;
            addr_s  = r0_addr;
            wdata_s = r0_wdata;
          end
          // memory-side outputs are registered, so they are loaded on entry to ACCESS
          gnt_s   = win_s ? 2'b10 : 2'b01;
          mode_s  = we_s ? MODE_WRITE : MODE_READ;
          maddr_s = addr_s;
          mdin_s  = wdata_s;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        state_s  = RESP;
        rvalid_s = idx_r ? 2'b10 : 2'b01;
        if (!we_r) begin
          cap_s = idx_r ? 2'b10 : 2'b01;
        end else begin
          cap_s = 2'b00;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // state, command and output registers; reset drops mem_mode at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      idx_r    <= 1'b0;
      we_r     <= 1'b0;
      addr_r   <= {ADDR_W{1'b0}};
      wdata_r  <= {DATA_W{1'b0}};
      last_r   <= 1'b1;
      gnt_r    <= 2'b00;
      rvalid_r <= 2'b00;
      mode_r   <= MODE_READ;
      maddr_r  <= {ADDR_W{1'b0}};
      mdin_r   <= {DATA_W{1'b0}};
    end else begin
      state_r  <= state_s;
      idx_r    <= idx_s;
      we_r     <= we_s;
      addr_r   <= addr_s;
      wdata_r  <= wdata_s;
      last_r   <= last_s;
      gnt_r    <= gnt_s;
      rvalid_r <= rvalid_s;
      mode_r   <= mode_s;
      maddr_r  <= maddr_s;
      mdin_r   <= mdin_s;
    end
  end

  // read data is captured only for reads and held across writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0_r <= {DATA_W{1'b0}};
      rdata1_r <= {DATA_W{1'b0}};
    end else begin
      if (cap_s[0]) begin
        rdata0_r <= mem_dataOut;
      end
      if (cap_s[1]) begin
        rdata1_r <= mem_dataOut;
      end
    end
  end

  assign r0_gnt      = gnt_r[0];
  assign r1_gnt      = gnt_r[1];
  assign r0_rvalid   = rvalid_r[0];
  assign r1_rvalid   = rvalid_r[1];
  assign r0_rdata    = rdata0_r;
  assign r1_rdata    = rdata1_r;
  assign mem_mode    = mode_r;
  assign mem_address = maddr_r;
  assign mem_dataIn  = mdin_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// against a transaction-level round-robin / memory reference model.
module tb_mem_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          r0_req, r0_we, r1_req, r1_we;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic          r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          mem_mode;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_dataIn, mem_dataOut;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_mode(mem_mode), .mem_address(mem_address), .mem_dataIn(mem_dataIn),
    .mem_dataOut(mem_dataOut)
  );

  // environment memory: combinational read, write on the clock edge
  logic [DW-1:0] mem [32];
  bit            mem_clr = 1'b1;
  assign mem_dataOut = mem[mem_address];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (mem_mode) begin
      mem[mem_address] <= mem_dataIn;
    end
  end

  // reference model state
  logic [DW-1:0] exp_mem [32];
  logic [DW-1:0] exp_rd [2];
  int            last_w;
  bit            pend [2];
  bit            p_we [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_data [2];
  int            n_cmp = 0;
  int            n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    r0_req = pend[0]; r0_we = p_we[0]; r0_addr = p_addr[0]; r0_wdata = p_data[0];
    r1_req = pend[1]; r1_we = p_we[1]; r1_addr = p_addr[1]; r1_wdata = p_data[1];
  endtask

  task automatic post(input int n, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[n] = 1'b1; p_we[n] = we; p_addr[n] = a; p_data[n] = d;
    drive();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_gnt"}, {30'd0, r1_gnt, r0_gnt}, 32'd0);
    check({tag, "_rvalid"}, {30'd0, r1_rvalid, r0_rvalid}, 32'd0);
    check({tag, "_mode"}, {31'd0, mem_mode}, 32'd0);
    check({tag, "_addr"}, {27'd0, mem_address}, 32'd0);
    check({tag, "_din"}, mem_dataIn, 32'd0);
  endtask

  // one arbitration: request sampled at the next edge, gnt then rvalid
  task automatic serve();
    int w;
    if (pend[0] && pend[1]) w = 1 - last_w;
    else if (pend[1])       w = 1;
    else                    w = 0;
    @(posedge clk); #1;
    check("gnt", {30'd0, r1_gnt, r0_gnt}, (w == 0) ? 32'd1 : 32'd2);
    check("acc_rvalid", {30'd0, r1_rvalid, r0_rvalid}, 32'd0);
    check("acc_mode", {31'd0, mem_mode}, {31'd0, p_we[w]});
    check("acc_addr", {27'd0, mem_address}, {27'd0, p_addr[w]});
    check("acc_din", mem_dataIn, p_data[w]);
    if (p_we[w]) exp_mem[p_addr[w]] = p_data[w];
    else         exp_rd[w] = exp_mem[p_addr[w]];
    last_w = w;
    pend[w] = 1'b0;
    drive();
    @(posedge clk); #1;
    check("rvalid", {30'd0, r1_rvalid, r0_rvalid}, (w == 0) ? 32'd1 : 32'd2);
    check("resp_gnt", {30'd0, r1_gnt, r0_gnt}, 32'd0);
    check("resp_mode", {31'd0, mem_mode}, 32'd0);
    check("r0_rdata", r0_rdata, exp_rd[0]);
    check("r1_rdata", r1_rdata, exp_rd[1]);
    @(posedge clk); #1;
    check_quiet("idle");
  endtask

  initial begin
    for (int i = 0; i < 32; i++) exp_mem[i] = '0;
    for (int n = 0; n < 2; n++) begin
      pend[n] = 1'b0; p_we[n] = 1'b0; p_addr[n] = '0; p_data[n] = '0; exp_rd[n] = '0;
    end
    last_w = 1;
    drive();
    rst_n = 1'b0;
    #2;
    check_quiet("rst");
    check("rst_rd0", r0_rdata, 32'd0);
    check("rst_rd1", r1_rdata, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    mem_clr = 1'b0;
    rst_n = 1'b1;

    // simultaneous requests straight after reset: r0 first, r1 three cycles later
    post(0, 1'b0, 5'd1, 32'h1111);
    post(1, 1'b0, 5'd2, 32'h2222);
    serve();
    serve();

    // write then read back through r0; a write leaves r0_rdata untouched
    post(0, 1'b1, 5'd0, 32'd3216);
    serve();
    post(0, 1'b0, 5'd0, 32'd0);
    serve();
    check("rd_3216", r0_rdata, 32'd3216);
    post(0, 1'b1, 5'd9, 32'hABCD);
    serve();
    check("wr_keeps_rdata", r0_rdata, 32'd3216);

    // both held continuously for six accesses: strict alternation
    post(0, 1'b1, 5'd10, 32'hA0);
    post(1, 1'b1, 5'd11, 32'hB0);
    for (int i = 0; i < 6; i++) begin
      serve();
      post(last_w, 1'b0, AW'(10 + last_w), 32'd0);
    end
    serve();
    serve();

    // top address, then address 0 must be unaffected
    post(1, 1'b1, 5'd31, 32'hFFFF_FFFF);
    serve();
    post(0, 1'b0, 5'd31, 32'd0);
    serve();
    check("rd_31", r0_rdata, 32'hFFFF_FFFF);
    post(0, 1'b0, 5'd0, 32'd0);
    serve();
    check("rd_0", r0_rdata, 32'd3216);

    // reset in the middle of a write to address 5
    post(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    check("ab_gnt", {30'd0, r1_gnt, r0_gnt}, 32'd1);
    check("ab_mode", {31'd0, mem_mode}, 32'd1);
    #2;
    rst_n = 1'b0;
    pend[0] = 1'b0;
    drive();
    #1;
    check_quiet("ab_rst");
    check("ab_rd0", r0_rdata, 32'd0);
    check("ab_rd1", r1_rdata, 32'd0);
    @(posedge clk); #1;
    check_quiet("ab_hold");
    #2;
    rst_n = 1'b1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    last_w = 1;
    post(0, 1'b0, 5'd5, 32'd0);
    post(1, 1'b0, 5'd31, 32'd0);
    serve();
    serve();

    // random traffic
    for (int t = 0; t < 60; t++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && ($urandom_range(0, 1) == 1)) begin
          post(n, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom);
        end
      end
      if (!pend[0] && !pend[1]) post(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom);
      serve();
    end
    while (pend[0] || pend[1]) serve();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
